// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared 640x480@60 timing constants, phase type and phase decode
package vga_pkg;

  localparam int ANCHO_CONT = 10;

  localparam int H_VISIBLE_STD = 640;
  localparam int H_FRONT_STD   = 16;
  localparam int H_SYNC_STD    = 96;
  localparam int H_BACK_STD    = 48;

  localparam int V_VISIBLE_STD = 480;
  localparam int V_FRONT_STD   = 10;
  localparam int V_SYNC_STD    = 2;
  localparam int V_BACK_STD    = 33;

  typedef enum logic [1:0] {VISIBLE, FRONT, SYNC, BACK} fase_t;

  // Bounds are the last count (inclusive) of each phase, in line/frame order.
  function automatic fase_t fase_de(input logic [ANCHO_CONT-1:0] cuenta,
                                    input int lim_visible,
                                    input int lim_front,
                                    input int lim_sync,
                                    input int lim_back);
    int c;
    c = int'(cuenta);
    if (c <= lim_visible) return VISIBLE;
    if (c <= lim_front)   return FRONT;
    if (c <= lim_sync)    return SYNC;
    if (c <= lim_back)    return BACK;
    // A wrapping counter never exceeds the last bound.
    return VISIBLE;
  endfunction

endpackage

// File: rtl/controlador_sincronia_vga_if.sv
// rtl/controlador_sincronia_vga_if.sv - timing bus between the VGA sync controller and the pixel logic
// master: the sync controller (takes tick_pixel/habilitar, drives syncs, video_on, coordinates, strobes)
// slave : the side that supplies the enables and consumes the timing
interface controlador_sincronia_vga_if;
  import vga_pkg::*;

  logic                  tick_pixel;
  logic                  habilitar;
  logic                  hsync;
  logic                  vsync;
  logic                  video_on;
  logic [ANCHO_CONT-1:0] pixel_x;
  logic [ANCHO_CONT-1:0] pixel_y;
  logic                  fin_linea;
  logic                  inicio_cuadro;

  modport master (
    input  tick_pixel, habilitar,
    output hsync, vsync, video_on, pixel_x, pixel_y, fin_linea, inicio_cuadro
  );

  modport slave (
    output tick_pixel, habilitar,
    input  hsync, vsync, video_on, pixel_x, pixel_y, fin_linea, inicio_cuadro
  );

endinterface

// File: rtl/contador_fase_vga.sv
// rtl/contador_fase_vga.sv - wrap counter with enable, synchronous clear, next-phase decode and wrap strobe
// Ports: clk_referencia, reset_n (async, active-low), habilitar_cuenta (advance one step),
//        limpiar (synchronous return to 0, wins over habilitar_cuenta), cuenta (registered count),
//        fase_sig (phase of the count being loaded this cycle), envuelve (this edge wraps TOTAL-1 -> 0)
module contador_fase_vga
  import vga_pkg::*;
#(
  parameter int N_VISIBLE = H_VISIBLE_STD,
  parameter int N_FRONT   = H_FRONT_STD,
  parameter int N_SYNC    = H_SYNC_STD,
  parameter int N_BACK    = H_BACK_STD
) (
  input  logic                  clk_referencia,
  input  logic                  reset_n,
  input  logic                  habilitar_cuenta,
  input  logic                  limpiar,
  output logic [ANCHO_CONT-1:0] cuenta,
  output fase_t                 fase_sig,
  output logic                  envuelve
);

  localparam int TOTAL = N_VISIBLE + N_FRONT + N_SYNC + N_BACK;
  localparam logic [ANCHO_CONT-1:0] ULTIMO = ANCHO_CONT'(TOTAL - 1);
  localparam logic [ANCHO_CONT-1:0] UNO    = ANCHO_CONT'(1);

  logic [ANCHO_CONT-1:0] cuenta_sig;

  always_ff @(posedge clk_referencia or negedge reset_n) begin
    if (!reset_n) begin
      cuenta <= '0;
    end else begin
      cuenta <= cuenta_sig;
    end
  end

  always_comb begin
    cuenta_sig = cuenta;
    if (limpiar) begin
      cuenta_sig = '0;
    end else if (habilitar_cuenta) begin
      cuenta_sig = (cuenta == ULTIMO) ? '0 : cuenta + UNO;
    end
  end

  // Phase is decoded from the next count so registered outputs line up with cuenta.
  always_comb begin
    fase_sig = fase_de(cuenta_sig,
                       N_VISIBLE - 1,
                       N_VISIBLE + N_FRONT - 1,
                       N_VISIBLE + N_FRONT + N_SYNC - 1,
                       TOTAL - 1);
    envuelve = habilitar_cuenta && !limpiar && (cuenta == ULTIMO);
  end

endmodule

// File: rtl/controlador_sincronia_vga.sv
// rtl/controlador_sincronia_vga.sv - VGA 640x480@60 sync/timing controller in the 50 MHz domain
// Ports: clk_referencia (50 MHz), reset_n (async, active-low),
//        vga (master): tick_pixel, habilitar in; hsync, vsync, video_on, pixel_x, pixel_y,
//        fin_linea, inicio_cuadro out (all registered)
module controlador_sincronia_vga
  import vga_pkg::*;
#(
  parameter int   H_VISIBLE   = H_VISIBLE_STD,
  parameter int   H_FRONT     = H_FRONT_STD,
  parameter int   H_SYNC      = H_SYNC_STD,
  parameter int   H_BACK      = H_BACK_STD,
  parameter int   V_VISIBLE   = V_VISIBLE_STD,
  parameter int   V_FRONT     = V_FRONT_STD,
  parameter int   V_SYNC      = V_SYNC_STD,
  parameter int   V_BACK      = V_BACK_STD,
  parameter logic SYNC_ACTIVO = 1'b0
) (
  input  logic                         clk_referencia,
  input  logic                         reset_n,
  controlador_sincronia_vga_if.master  vga
);

  logic                  avance;
  logic                  limpiar;
  logic [ANCHO_CONT-1:0] cuenta_h;
  logic [ANCHO_CONT-1:0] cuenta_v;
  fase_t                 fase_h_sig;
  fase_t                 fase_v_sig;
  logic                  envuelve_h;
  logic                  envuelve_v;
  logic                  hsync_q;
  logic                  vsync_q;
  logic                  video_q;
  logic                  fin_linea_q;
  logic                  inicio_cuadro_q;

  assign avance  = vga.tick_pixel & vga.habilitar;
  assign limpiar = ~vga.habilitar;

  contador_fase_vga #(
    .N_VISIBLE (H_VISIBLE),
    .N_FRONT   (H_FRONT),
    .N_SYNC    (H_SYNC),
    .N_BACK    (H_BACK)
  ) u_contador_h (
    .clk_referencia   (clk_referencia),
    .reset_n          (reset_n),
    .habilitar_cuenta (avance),
    .limpiar          (limpiar),
    .cuenta           (cuenta_h),
    .fase_sig         (fase_h_sig),
    .envuelve         (envuelve_h)
  );

  // Lines advance only on the edge where the pixel counter wraps.
  contador_fase_vga #(
    .N_VISIBLE (V_VISIBLE),
    .N_FRONT   (V_FRONT),
    .N_SYNC    (V_SYNC),
    .N_BACK    (V_BACK)
  ) u_contador_v (
    .clk_referencia   (clk_referencia),
    .reset_n          (reset_n),
    .habilitar_cuenta (envuelve_h),
    .limpiar          (limpiar),
    .cuenta           (cuenta_v),
    .fase_sig         (fase_v_sig),
    .envuelve         (envuelve_v)
  );

  // video_on is forced low at the origin after reset or disable and only
  // rises with the first qualified tick, so it is held rather than decoded
  // on idle cycles.
  always_ff @(posedge clk_referencia or negedge reset_n) begin
    if (!reset_n) begin
      hsync_q         <= ~SYNC_ACTIVO;
      vsync_q         <= ~SYNC_ACTIVO;
      video_q         <= 1'b0;
      fin_linea_q     <= 1'b0;
      inicio_cuadro_q <= 1'b0;
    end else if (limpiar) begin
      hsync_q         <= ~SYNC_ACTIVO;
      vsync_q         <= ~SYNC_ACTIVO;
      video_q         <= 1'b0;
      fin_linea_q     <= 1'b0;
      inicio_cuadro_q <= 1'b0;
    end else begin
      if (avance) begin
        hsync_q <= (fase_h_sig == SYNC) ? SYNC_ACTIVO : ~SYNC_ACTIVO;
        vsync_q <= (fase_v_sig == SYNC) ? SYNC_ACTIVO : ~SYNC_ACTIVO;
        video_q <= (fase_h_sig == VISIBLE) && (fase_v_sig == VISIBLE);
      end
      fin_linea_q     <= envuelve_h;
      inicio_cuadro_q <= envuelve_h & envuelve_v;
    end
  end

  assign vga.pixel_x       = cuenta_h;
  assign vga.pixel_y       = cuenta_v;
  assign vga.hsync         = hsync_q;
  assign vga.vsync         = vsync_q;
  assign vga.video_on      = video_q;
  assign vga.fin_linea     = fin_linea_q;
  assign vga.inicio_cuadro = inicio_cuadro_q;

endmodule

// File: doc/controlador_sincronia_vga.md
Name: controlador_sincronia_vga

Overview:
- VGA 640x480@60 timing controller that sequences the pixel-rate datapath.
- Consumes the 25 MHz pixel tick, which is a one-in-two enable derived from the 50 MHz reference clock.
- Produces hsync, vsync, video_on and the pixel_x/pixel_y coordinates, plus line and frame strobes for the pixel generator.
- Sits between the frequency divider and the pixel/colour logic; everything runs in the 50 MHz domain.

Parameters:
H_VISIBLE, 640, visible pixels per line
H_FRONT, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BACK, 48, horizontal back porch (pixels)
V_VISIBLE, 480, visible lines per frame
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BACK, 33, vertical back porch (lines)
SYNC_ACTIVO, 0, logic level of an asserted hsync/vsync (0 = active-low)

Ports:
clk_referencia  input  1  50 MHz system clock
reset_n  input  1  asynchronous active-low reset
tick_pixel  input  1  one-cycle pixel enable, nominally every 2nd clk_referencia cycle
habilitar  input  1  run enable; 0 = synchronous return to origin
hsync  output  1  horizontal sync, registered
vsync  output  1  vertical sync, registered
video_on  output  1  1 inside the 640x480 visible region, registered
pixel_x  output  10  current column, 0..H_TOTAL-1
pixel_y  output  10  current line, 0..V_TOTAL-1
fin_linea  output  1  one-clk_referencia pulse on horizontal wrap
inicio_cuadro  output  1  one-clk_referencia pulse on frame wrap

Behaviour:
- Totals: H_TOTAL = sum of the four H parameters = 800. V_TOTAL = sum of the four V parameters = 525. Counters are 10 bits, unsigned.
- Reset (reset_n=0, asynchronous): pixel_x=0, pixel_y=0, hsync=vsync=~SYNC_ACTIVO, video_on=0, fin_linea=0, inicio_cuadro=0.
- Counter advance: only on a clk_referencia edge with tick_pixel=1 and habilitar=1. Otherwise counters and sync/video outputs hold, and the strobes are 0.
- Horizontal counter: increments by 1. At H_TOTAL-1 it wraps to 0, and the vertical counter increments on that same edge.
- Vertical counter: wraps from V_TOTAL-1 to 0 when the horizontal counter wraps.
- Output alignment: hsync, vsync and video_on are registered from the next-state counter values. They are therefore always consistent with the pixel_x/pixel_y shown in the same cycle (zero relative latency).
- Horizontal phase FSM (in the package): VISIBLE [0, 639], FRONT [640, 655], SYNC [656, 751], BACK [752, 799]. The vertical FSM is identical over lines: VISIBLE [0, 479], FRONT [480, 489], SYNC [490, 491], BACK [492, 524].
- hsync = SYNC_ACTIVO only while the horizontal FSM is in SYNC; vsync likewise for the vertical FSM.
- video_on = (H in VISIBLE) AND (V in VISIBLE).
- fin_linea: 1 for exactly one clk_referencia cycle after the edge where pixel_x wraps 799 -> 0.
- inicio_cuadro: 1 for exactly one cycle after the edge where pixel_x wraps 799 -> 0 and pixel_y wraps 524 -> 0. It coincides with fin_linea.
- habilitar=0: on the next clk edge, independent of tick_pixel, all outputs take their reset values. While habilitar stays 0 the block stays at the origin. On re-enable, the first qualified tick_pixel produces pixel_x=1, with video_on=1 and syncs inactive.
- Irregular tick_pixel (back-to-back, or gaps > 1 cycle): each qualified tick advances exactly one pixel, with no lost or double counts.
- Reset asserted mid-frame: immediate return to origin with no strobe emitted. Sync release happens on the first clock after reset deasserts.

Decomposition:
- Package vga_pkg holds:
  - the 640x480@60 timing constants;
  - the phase enum fase_t (VISIBLE, FRONT, SYNC, BACK);
  - the counter width constant (10);
  - a function mapping (count, four bounds) to fase_t.
- Sub-module contador_fase_vga: parameterised wrap counter with enable, synchronous clear, phase decode and wrap strobe. It is instantiated twice: horizontal counter enabled by the tick, vertical counter enabled by the horizontal wrap.

Test Plan:
- Reset: hold reset_n=0 with random tick_pixel -> pixel_x=0, pixel_y=0, hsync=vsync=1, video_on=0, both strobes 0.
- Line timing: tick every 2nd clock, habilitar=1 -> hsync low for exactly 96 ticks (pixel_x 656..751) and video_on high for 640 ticks per line; fin_linea pulses every 1600 clocks, 1 clock wide.
- Frame timing: run 1 full frame -> vsync low only while pixel_y is 490..491 (1600 ticks); inicio_cuadro is a single pulse after 800*525 = 420000 ticks, coincident with fin_linea.
- Irregular enable: tick_pixel pattern 1,1,0,0,0,1 repeated -> pixel_x advances exactly by the count of ticks; sync/video remain consistent with pixel_x/pixel_y in every cycle (checker compares against the reference decode).
- Mid-frame abort: deassert habilitar at (700,300) -> next clock (0,0), syncs inactive, video_on=0; re-enable -> first tick gives pixel_x=1, video_on=1.
- Asynchronous reset at (655,489) between clock edges -> outputs reset immediately without waiting for a clock; no strobe emitted.
